// File: rtl/serial_parity_tx.sv
// serial_parity_tx
// Serializes a DATA_WIDTH-bit word into a frame on a single line:
//   start bit (0), data bits LSB first, parity bit, stop bit (1).
// The parity bit is even by default, or odd when ODD_PARITY is nonzero.
//
// Ports:
//   clk        - sole clock, rising edge
//   reset      - asynchronous, active-low reset
//   start      - transmit request, looked at only while idle
//   data_in    - word to send, captured on the edge that accepts start
//   serial_out - serial line, idles high
//   busy       - high for every cycle of a frame (start through stop)
//   done       - one-cycle pulse in the first idle cycle after the stop bit
module serial_parity_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int ODD_PARITY = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  serial_out,
    output logic                  busy,
    output logic                  done
);

    // The counter has to hold DATA_WIDTH itself, so it gets one extra code.
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic [DATA_WIDTH-1:0]   shift_reg;
    logic [CNT_W-1:0]        bit_cnt;
    logic                    parity_bit;

    // State register. Reset sends the machine straight back to IDLE,
    // abandoning any frame in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. Start is only examined in IDLE, so a request
    // made during a frame is simply dropped rather than queued. DATA
    // is left after bit_cnt has counted DATA_WIDTH shift cycles.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (start) next_state = START;
            START:   next_state = DATA;
            DATA:    if (bit_cnt == CNT_W'(DATA_WIDTH - 1)) next_state = PARITY;
            PARITY:  next_state = STOP;
            STOP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath. The word and its parity are captured together on the
    // accepting edge, so later changes on data_in cannot leak into the
    // frame. The shift register moves one bit per DATA cycle so that
    // bit 0 is always the bit currently on the line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_reg  <= '0;
            bit_cnt    <= '0;
            parity_bit <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                shift_reg  <= data_in;
                bit_cnt    <= '0;
                parity_bit <= (^data_in) ^ (ODD_PARITY != 0);
            end else if (state == DATA) begin
                shift_reg  <= shift_reg >> 1;
                bit_cnt    <= bit_cnt + CNT_W'(1);
            end
        end
    end

    // The done pulse is registered off the STOP state, which puts it in
    // exactly the first IDLE cycle after the frame. A reset mid-frame
    // never passes through STOP, so no pulse follows it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done <= 1'b0;
        end else begin
            done <= (state == STOP);
        end
    end

    // Line and busy outputs depend only on the current state.
    always_comb begin
        serial_out = 1'b1;
        busy       = 1'b1;
        unique case (state)
            IDLE:    begin serial_out = 1'b1;         busy = 1'b0; end
            START:   serial_out = 1'b0;
            DATA:    serial_out = shift_reg[0];
            PARITY:  serial_out = parity_bit;
            STOP:    serial_out = 1'b1;
            default: begin serial_out = 1'b1;         busy = 1'b0; end
        endcase
    end

endmodule

// File: tb/tb_serial_parity_tx.sv
// tb_serial_parity_tx
// Drives three copies of serial_parity_tx side by side:
//   dut 0: 8 data bits, even parity
//   dut 1: 8 data bits, odd parity
//   dut 2: 1 data bit, even parity
// A frame-position model predicts every output on every cycle, and the
// directed sequences add hand-worked literal expectations on top.
module tb_serial_parity_tx;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_v [3];
    logic [31:0] data_v  [3];
    logic        so [3];
    logic        bz [3];
    logic        dn [3];

    int checks_total  = 0;
    int checks_passed = 0;

    // Model state: position within the frame for each dut.
    // -1 idle, 0 start bit, 1..W data bits, W+1 parity, W+2 stop,
    // W+3 the idle cycle carrying the done pulse.
    int          wid [3] = '{8, 8, 1};
    int          odd [3] = '{0, 1, 0};
    int          pos [3] = '{-1, -1, -1};
    logic [31:0] lat [3];

    serial_parity_tx #(.DATA_WIDTH(8), .ODD_PARITY(0)) dut_even (
        .clk(clk), .reset(reset), .start(start_v[0]), .data_in(data_v[0][7:0]),
        .serial_out(so[0]), .busy(bz[0]), .done(dn[0])
    );

    serial_parity_tx #(.DATA_WIDTH(8), .ODD_PARITY(1)) dut_odd (
        .clk(clk), .reset(reset), .start(start_v[1]), .data_in(data_v[1][7:0]),
        .serial_out(so[1]), .busy(bz[1]), .done(dn[1])
    );

    serial_parity_tx #(.DATA_WIDTH(1), .ODD_PARITY(0)) dut_w1 (
        .clk(clk), .reset(reset), .start(start_v[2]), .data_in(data_v[2][0:0]),
        .serial_out(so[2]), .busy(bz[2]), .done(dn[2])
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    function automatic logic [31:0] width_mask(input int w);
        logic [31:0] m;
        m = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return m;
    endfunction

    // Expected line level at a given frame position, straight from the
    // frame definition: 0, data LSB first, parity over the word, 1.
    function automatic logic exp_serial(input logic [31:0] d, input int w,
                                        input int odd_p, input int idx);
        logic p;
        if (idx == 0) return 1'b0;
        if (idx <= w) return d[idx-1];
        if (idx == w + 1) begin
            p = ^(d & width_mask(w));
            return p ^ (odd_p != 0);
        end
        return 1'b1;
    endfunction

    // Model advance: an idle dut (plain idle or done cycle) accepts start
    // and captures the word; otherwise it moves one position along.
    always @(posedge clk or negedge reset) begin
        for (int i = 0; i < 3; i++) begin
            if (!reset) begin
                pos[i] <= -1;
            end else if (pos[i] < 0 || pos[i] == wid[i] + 3) begin
                if (start_v[i]) begin
                    pos[i] <= 0;
                    lat[i] <= data_v[i] & width_mask(wid[i]);
                end else begin
                    pos[i] <= -1;
                end
            end else begin
                pos[i] <= pos[i] + 1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks_total++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int which, input logic s, input logic [31:0] d);
        start_v[which] = s;
        data_v[which]  = d;
    endtask

    // Every falling edge, each dut's three outputs are set against the model.
    task automatic compareLoop();
        logic es, eb, ed;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (pos[i] < 0) begin
                    es = 1'b1; eb = 1'b0; ed = 1'b0;
                end else if (pos[i] <= wid[i] + 2) begin
                    es = exp_serial(lat[i], wid[i], odd[i], pos[i]); eb = 1'b1; ed = 1'b0;
                end else begin
                    es = 1'b1; eb = 1'b0; ed = 1'b1;
                end
                checkOutput($sformatf("model dut%0d serial_out", i), 32'(so[i]), 32'(es));
                checkOutput($sformatf("model dut%0d busy", i), 32'(bz[i]), 32'(eb));
                checkOutput($sformatf("model dut%0d done", i), 32'(dn[i]), 32'(ed));
            end
        end
    endtask

    initial begin
        logic [10:0] cap;
        logic [3:0]  cap4;
        int          cnt_busy;
        int          cnt_done;
        int          rises;
        int          last_rise;
        logic        prev_busy;

        for (int i = 0; i < 3; i++) applyStimulus(i, 1'b0, 32'h0);
        fork
            compareLoop();
        join_none

        // Reset state, held for a few cycles.
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("reset dut%0d serial_out", i), 32'(so[i]), 32'd1);
            checkOutput($sformatf("reset dut%0d busy", i), 32'(bz[i]), 32'd0);
            checkOutput($sformatf("reset dut%0d done", i), 32'(dn[i]), 32'd0);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // 0xA5, even parity: 0,1,0,1,0,0,1,0,1,0,1 then one done.
        applyStimulus(0, 1'b1, 32'hA5);
        @(negedge clk);
        applyStimulus(0, 1'b0, 32'hA5);
        cnt_busy = 0;
        for (int i = 0; i < 11; i++) begin
            cap[i] = so[0];
            cnt_busy += int'(bz[0]);
            @(negedge clk);
        end
        checkOutput("A5 frame bits", 32'(cap), 32'(11'b10101001010));
        checkOutput("A5 busy cycles", 32'(cnt_busy), 32'd11);
        checkOutput("A5 done pulse", 32'(dn[0]), 32'd1);
        @(negedge clk);
        checkOutput("A5 done clears", 32'(dn[0]), 32'd0);

        // 0x01: odd parity bit is 0, even parity bit is 1.
        applyStimulus(0, 1'b1, 32'h01);
        applyStimulus(1, 1'b1, 32'h01);
        @(negedge clk);
        applyStimulus(0, 1'b0, 32'h01);
        applyStimulus(1, 1'b0, 32'h01);
        repeat (9) @(negedge clk);
        checkOutput("0x01 odd parity bit", 32'(so[1]), 32'd0);
        checkOutput("0x01 even parity bit", 32'(so[0]), 32'd1);
        repeat (3) @(negedge clk);

        // 0x3C frame with start held and data_in moved to 0xFF mid-frame.
        applyStimulus(0, 1'b1, 32'h3C);
        @(negedge clk);
        applyStimulus(0, 1'b1, 32'hFF);
        for (int i = 0; i < 11; i++) begin
            cap[i] = so[0];
            if (i == 10) applyStimulus(0, 1'b0, 32'hFF);
            @(negedge clk);
        end
        checkOutput("3C frame bits", 32'(cap), 32'(11'b10001111000));
        cnt_done = 0;
        for (int i = 0; i < 4; i++) begin
            cnt_done += int'(dn[0]);
            @(negedge clk);
        end
        checkOutput("3C done count", 32'(cnt_done), 32'd1);

        // Asynchronous reset between edges while in DATA.
        applyStimulus(0, 1'b1, 32'hFF);
        @(negedge clk);
        applyStimulus(0, 1'b0, 32'hFF);
        repeat (3) @(negedge clk);
        checkOutput("pre-reset busy", 32'(bz[0]), 32'd1);
        #2 reset = 1'b0;
        #1;
        checkOutput("async reset serial_out", 32'(so[0]), 32'd1);
        checkOutput("async reset busy", 32'(bz[0]), 32'd0);
        checkOutput("async reset done", 32'(dn[0]), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        cnt_busy = 0;
        cnt_done = 0;
        for (int i = 0; i < 15; i++) begin
            cnt_busy += int'(bz[0]);
            cnt_done += int'(dn[0]);
            @(negedge clk);
        end
        checkOutput("post-reset busy cycles", 32'(cnt_busy), 32'd0);
        checkOutput("post-reset done count", 32'(cnt_done), 32'd0);

        // Start held with 0x00: a new frame every 12 cycles.
        applyStimulus(0, 1'b1, 32'h00);
        @(negedge clk);
        rises = 0;
        last_rise = -12;
        cnt_done = 0;
        prev_busy = 1'b0;
        for (int i = 0; i < 48; i++) begin
            if (bz[0] && !prev_busy) begin
                checkOutput("back-to-back spacing", 32'(i - last_rise), 32'd12);
                last_rise = i;
                rises++;
            end
            if (i % 12 == 9) checkOutput("back-to-back parity", 32'(so[0]), 32'd0);
            prev_busy = bz[0];
            cnt_done += int'(dn[0]);
            if (i == 47) applyStimulus(0, 1'b0, 32'h00);
            @(negedge clk);
        end
        checkOutput("back-to-back frames", 32'(rises), 32'd4);
        checkOutput("back-to-back done count", 32'(cnt_done), 32'd4);
        repeat (2) @(negedge clk);

        // One-bit width, data 1: 0,1,1,1 and busy for 4 cycles.
        applyStimulus(2, 1'b1, 32'h1);
        @(negedge clk);
        applyStimulus(2, 1'b0, 32'h1);
        cnt_busy = 0;
        for (int i = 0; i < 4; i++) begin
            cap4[i] = so[2];
            cnt_busy += int'(bz[2]);
            @(negedge clk);
        end
        checkOutput("w1 frame bits", 32'(cap4), 32'(4'b1110));
        checkOutput("w1 busy cycles", 32'(cnt_busy), 32'd4);
        checkOutput("w1 done pulse", 32'(dn[2]), 32'd1);
        @(negedge clk);
        checkOutput("w1 idle busy", 32'(bz[2]), 32'd0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/serial_parity_tx.md
SERIAL_PARITY_TX -- requirements
Module: serial_parity_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, number of data bits per frame (legal range 1..32).
REQ-002 SHALL have parameter ODD_PARITY, default 0; 0 = even parity bit, 1 = odd parity bit.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (reset = 0 resets the block immediately, independent of clk).
REQ-005 SHALL have port start  input  1  request to transmit data_in; sampled only in IDLE.
REQ-006 SHALL have port data_in  input  DATA_WIDTH  parallel word to serialize.
REQ-007 SHALL have port serial_out  output  1  serial line; idle level 1.
REQ-008 SHALL have port busy  output  1  high while a frame is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse marking frame completion.

Function
REQ-010 SHALL implement an FSM with states IDLE, START, DATA, PARITY, STOP.
REQ-011 SHALL, in IDLE with start = 1 at a rising edge, latch data_in into a shift register, clear the bit counter, and move to START.
REQ-012 SHALL, in IDLE with start = 0, remain in IDLE.
REQ-013 SHALL move START -> DATA after exactly one cycle.
REQ-014 SHALL remain in DATA for exactly DATA_WIDTH cycles, shifting the register right by one per cycle (LSB first), then move to PARITY.
REQ-015 SHALL move PARITY -> STOP after one cycle and STOP -> IDLE after one cycle.
REQ-016 SHALL drive serial_out combinationally from state: IDLE 1, START 0, DATA shift-register bit 0, PARITY parity bit, STOP 1.
REQ-017 SHALL compute the parity bit from the latched word: XOR of all bits when ODD_PARITY = 0, inverted XOR when ODD_PARITY = 1.
REQ-018 SHALL make the total frame length DATA_WIDTH + 3 cycles, from the first START cycle through the STOP cycle.
REQ-019 SHALL assert busy = 1 in START, DATA, PARITY and STOP, and busy = 0 in IDLE.
REQ-020 SHALL assert done = 1 for exactly the first IDLE cycle after STOP (registered pulse), and 0 otherwise.
REQ-021 SHALL ignore start while busy = 1; no queuing and no frame restart.
REQ-022 SHALL ignore changes on data_in after the latch edge for the rest of the frame.
REQ-023 SHALL accept start in the same cycle done = 1 (IDLE), giving a minimum frame-to-frame spacing of DATA_WIDTH + 4 cycles.
REQ-024 SHALL size the bit counter as ceil(log2(DATA_WIDTH+1)) bits, with no wrap-around within a frame.

Reset
REQ-025 SHALL, on reset = 0 asynchronously and at any point including mid-frame, force state IDLE, shift register 0, counter 0, done 0.
REQ-026 SHALL keep outputs at serial_out = 1, busy = 0, done = 0 while reset = 0 and on the first cycle after release.
REQ-027 SHALL NOT emit a partial frame or a done pulse after a mid-frame reset; the next frame requires a new start.

Verification
REQ-028 Verification SHALL cover: DATA_WIDTH = 8, ODD_PARITY = 0, data_in = 0xA5, start pulse -> serial_out 0,1,0,1,0,0,1,0,1,0,1 over 11 cycles, then done = 1 for one cycle.
REQ-029 Verification SHALL cover: ODD_PARITY = 1, data_in = 0x01 -> parity-bit cycle drives 0; the same word with ODD_PARITY = 0 drives 1.
REQ-030 Verification SHALL cover: start re-asserted and data_in changed to 0xFF during a 0x3C frame -> frame still shows 0x3C bits, parity 0, and exactly one done pulse.
REQ-031 Verification SHALL cover: reset = 0 asserted between clock edges during the DATA state -> serial_out = 1 and busy = 0 immediately, and no done pulse follows.
REQ-032 Verification SHALL cover: start held high continuously with data_in = 0x00 -> back-to-back frames every 12 cycles, each with parity 0 and one done pulse each.
REQ-033 Verification SHALL cover: DATA_WIDTH = 1, data_in = 1 -> serial_out 0,1,1,1 (start, data, even parity, stop) and busy high for 4 cycles.
